ntt_butterfly_scheduler: RTL
============================

Name: ntt_butterfly_scheduler

Overview:
- Control stage directly upstream of ntt_intt_pe_cell.
- Sequences a radix-2 Cooley-Tukey NTT/INTT over a 2^LOG_N-point vector (bit-reversed input order).
- Per butterfly, emits coefficient-RAM read addresses for operands a and b, the twiddle ROM index feeding tf, and the inv flag, with valid/ready handshake.
- Inserts a drain gap between stages so in-flight PE writebacks land before the next stage reads.

Parameters:
LOG_N, 8, log2 of transform length; N = 2^LOG_N, legal 2..12
PIPE_DRAIN, 4, idle cycles inserted after each stage's last accepted beat, legal 0..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a transform; sampled only in IDLE
inv_mode  input  1  transform direction, latched when start is accepted
busy  output  1  high from accepted start through DONE
done  output  1  one-cycle pulse at completion
out_valid  output  1  beat available
out_ready  input  1  downstream accepts beat
addr_a  output  LOG_N  RAM address of operand a
addr_b  output  LOG_N  RAM address of operand b
tf_addr  output  LOG_N-1  twiddle ROM index
inv  output  1  latched inv_mode, drives PE inv
stage  output  $clog2(LOG_N)  current stage index
last  output  1  high on final beat of the transform

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0. Counters 0. Reset mid-transform aborts immediately; no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 latches inv_mode, clears s and bf, goes to ISSUE. busy and out_valid rise the next cycle (1-cycle latency).
  - ISSUE: out_valid=1. On out_valid&&out_ready, bf increments.
    - If bf was N/2-1 and s<LOG_N-1: bf<=0, s<=s+1, go to DRAIN.
    - If bf was N/2-1 and s==LOG_N-1: go to DRAIN (final).
  - DRAIN: out_valid=0 for exactly PIPE_DRAIN cycles. Then go to ISSUE, or to DONE if final. With PIPE_DRAIN=0, DRAIN is skipped entirely and the next stage's first beat is valid the cycle after acceptance.
  - DONE: done=1 and busy=1 for one cycle, then IDLE.
- Address math for stage s, with half=2^s, k=bf mod half, grp=bf>>s:
  - addr_a = (grp<<(s+1)) | k
  - addr_b = addr_a + half
  - tf_addr = k<<(LOG_N-1-s)
  - All truncated to port width; no wrap beyond N-1 is possible.
- Beat count per transform: LOG_N*N/2.
- Handshake: while out_valid && !out_ready, every beat output holds stable. out_valid never drops without acceptance except on reset.
- start while busy is ignored. start coincident with the DONE cycle is ignored.
- inv holds its latched value from accept of start until the next accepted start. A change of inv_mode mid-transform has no effect.
- last = out_valid && s==LOG_N-1 && bf==N/2-1.

Optional Feature:
NTT_SCHED_SCALE_PASS_EN
- Defined:
  - Adds output port scale (1 bit).
  - When the latched inv_mode=1, after the final stage's DRAIN the FSM enters SCALE instead of DONE.
  - SCALE emits N beats i=0..N-1 with addr_a=addr_b=i, tf_addr=0, scale=1, stage=LOG_N-1, under the same handshake, for multiplication by N^-1.
  - last moves to beat i=N-1 of SCALE.
  - After SCALE: PIPE_DRAIN drain cycles, then DONE.
  - scale=0 in all other states; reset value 0.
- Undefined: no scale port and no SCALE state; behaviour is exactly as above.

Decomposition:
- Shared package ntt_pkg holds:
  - FSM state enum (IDLE, ISSUE, DRAIN, SCALE, DONE)
  - the LOG_N-derived width constants, stage-index width function, and N/2 butterfly-count constant also used by the coefficient RAM and twiddle ROM.
- One natural sub-module: ntt_bf_addr_gen. Combinational mapping (s, bf) -> (addr_a, addr_b, tf_addr), reusable by the writeback address path.
- FSM and counters stay in the top.

Test Plan:
1. LOG_N=3, PIPE_DRAIN=0, out_ready=1, start pulse -> 12 beats (a,b,tf):
   - stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
   - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
   - stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
   - last on beat 12; done one cycle later.
2. LOG_N=3, PIPE_DRAIN=4 -> exactly 4 out_valid-low cycles after beats 4, 8 and 12; total start-to-done = 1+12+12+1 = 26 cycles.
3. Random out_ready stalls -> beat outputs bit-stable across every stall cycle; sequence identical to test 1.
4. start=1 while busy, and an inv_mode toggle mid-transform -> ignored; inv equals the value latched at first start.
5. rst_n low during stage 1 beat 2 -> all outputs 0 asynchronously, no done pulse; a fresh start after release replays from (0,1,0).
6. Macro defined, LOG_N=3, inv_mode=1 -> after 12 butterfly beats, 8 scale beats with addr_a=addr_b=0..7, tf_addr=0, scale=1, last on i=7. With inv_mode=0 -> no scale beats.

Source files
------------

// File: rtl/ntt_butterfly_scheduler_pkg.sv
// ntt_pkg: FSM state codes, width helpers and butterfly-count helper shared by the
// NTT scheduler, coefficient RAM and twiddle ROM.
package ntt_pkg;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 3'd0;
  localparam sched_state_t ST_ISSUE = 3'd1;
  localparam sched_state_t ST_DRAIN = 3'd2;
  localparam sched_state_t ST_SCALE = 3'd3;
  localparam sched_state_t ST_DONE  = 3'd4;

  // Stage index width; at least one bit even for the smallest transform.
  function automatic int stage_w(input int log_n);
    if (log_n <= 2) begin
      return 1;
    end else begin
      return $clog2(log_n);
    end
  endfunction

  // Butterflies per stage (N/2).
  function automatic int bf_count(input int log_n);
    return 32'd1 << (log_n - 1);
  endfunction

endpackage

// File: rtl/ntt_butterfly_scheduler_bf_addr_gen.sv
// ntt_bf_addr_gen: combinational (stage, butterfly) -> operand/twiddle address map for
// a radix-2 Cooley-Tukey pass over bit-reversed input.
module ntt_bf_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOG_N = 8
) (
  input  logic [stage_w(LOG_N)-1:0] s,
  input  logic [LOG_N-2:0]          bf,
  output logic [LOG_N-1:0]          addr_a,
  output logic [LOG_N-1:0]          addr_b,
  output logic [LOG_N-2:0]          tf_addr
);

  localparam int SW = stage_w(LOG_N);
  localparam logic [SW-1:0]    S_TOP = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] ONE   = LOG_N'(1'b1);

  logic [LOG_N-1:0] bf_ext_s;
  logic [LOG_N-1:0] half_s;
  logic [LOG_N-1:0] mask_s;
  logic [LOG_N-1:0] a_s;
  logic [SW-1:0]    tf_sh_s;

  // Group index moves up one bit to open the gap for the b operand; k stays in place.
  always_comb begin
    bf_ext_s = {1'b0, bf};
    half_s   = ONE << s;
    mask_s   = half_s - ONE;
    a_s      = (((bf_ext_s >> s) << s) << 1'b1) | (bf_ext_s & mask_s);
    tf_sh_s  = S_TOP - s;
    addr_a   = a_s;
    addr_b   = a_s + half_s;
    tf_addr  = (bf & mask_s[LOG_N-2:0]) << tf_sh_s;
  end

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// ntt_butterfly_scheduler: issues NTT/INTT butterfly beats stage by stage with a drain gap.
// Optional INTT N^-1 scaling pass enabled by defining NTT_SCHED_SCALE_PASS_EN.
module ntt_butterfly_scheduler
  import ntt_pkg::*;
#(
  parameter int LOG_N      = 8,
  parameter int PIPE_DRAIN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      inv_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LOG_N-1:0]          addr_a,
  output logic [LOG_N-1:0]          addr_b,
  output logic [LOG_N-2:0]          tf_addr,
  output logic                      inv,
  output logic [stage_w(LOG_N)-1:0] stage,
  output logic                      last
`ifdef NTT_SCHED_SCALE_PASS_EN
  ,
  output logic                      scale
`endif
);

  localparam int SW   = stage_w(LOG_N);
  localparam int BF_N = bf_count(LOG_N);
  localparam logic [SW-1:0]    S_LAST     = SW'(LOG_N - 1);
  localparam logic [LOG_N-1:0] BF_LAST    = LOG_N'(BF_N - 1);
  localparam logic [3:0]       DRAIN_LAST = 4'(PIPE_DRAIN - 1);
`ifdef NTT_SCHED_SCALE_PASS_EN
  localparam logic             SCALE_EN   = 1'b1;
  localparam logic [LOG_N-1:0] SC_LAST    = {LOG_N{1'b1}};
`else
  localparam logic             SCALE_EN   = 1'b0;
`endif

  sched_state_t     state_r, state_n, after_r, after_n, fin_tgt_s;
  logic [SW-1:0]    s_r, s_n;
  logic [LOG_N-1:0] bf_r, bf_n;
  logic [3:0]       drain_r, drain_n;
  logic             inv_n, fire_s;
  logic             valid_n, last_n;
  logic [LOG_N-1:0] a_n, b_n, gen_a_s, gen_b_s;
  logic [LOG_N-2:0] tf_n, gen_tf_s;
`ifdef NTT_SCHED_SCALE_PASS_EN
  logic             scale_n;
`endif

  ntt_bf_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
    .s       (s_n),
    .bf      (bf_n[LOG_N-2:0]),
    .addr_a  (gen_a_s),
    .addr_b  (gen_b_s),
    .tf_addr (gen_tf_s)
  );

  // Where the FSM heads once the final butterfly stage has drained.
  always_comb begin
`ifdef NTT_SCHED_SCALE_PASS_EN
    fin_tgt_s = inv ? ST_SCALE : ST_DONE;
`else
    fin_tgt_s = ST_DONE;
`endif
  end

  // FSM next-state and stage/butterfly/drain counter update.
  always_comb begin
    state_n = state_r;
    after_n = after_r;
    s_n     = s_r;
    bf_n    = bf_r;
    drain_n = drain_r;
    inv_n   = inv;
    fire_s  = out_valid && out_ready;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          inv_n   = inv_mode;
          s_n     = '0;
          bf_n    = '0;
          drain_n = '0;
          state_n = ST_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (fire_s && (bf_r == BF_LAST)) begin
          bf_n = '0;
          if (s_r == S_LAST) begin
            after_n = fin_tgt_s;
          end else begin
            s_n     = s_r + SW'(1'b1);
            after_n = ST_ISSUE;
          end
          if (PIPE_DRAIN == 0) begin
            state_n = after_n;
          end else begin
            drain_n = '0;
            state_n = ST_DRAIN;
          end
        end else if (fire_s) begin
          bf_n = bf_r + LOG_N'(1'b1);
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_n = after_r;
        end else begin
          drain_n = drain_r + 4'd1;
        end
      end
`ifdef NTT_SCHED_SCALE_PASS_EN
      ST_SCALE: begin
        if (fire_s && (bf_r == SC_LAST)) begin
          bf_n    = '0;
          after_n = ST_DONE;
          if (PIPE_DRAIN == 0) begin
            state_n = ST_DONE;
          end else begin
            drain_n = '0;
            state_n = ST_DRAIN;
          end
        end else if (fire_s) begin
          bf_n = bf_r + LOG_N'(1'b1);
        end else begin
          state_n = ST_SCALE;
        end
      end
`endif
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Beat payload as it will appear after the coming edge; held automatically on stall.
  always_comb begin
    valid_n = (state_n == ST_ISSUE) || (state_n == ST_SCALE);
    a_n     = gen_a_s;
    b_n     = gen_b_s;
    tf_n    = gen_tf_s;
    last_n  = 1'b0;
`ifdef NTT_SCHED_SCALE_PASS_EN
    scale_n = 1'b0;
`endif
    if (state_n == ST_ISSUE) begin
      last_n = (s_n == S_LAST) && (bf_n == BF_LAST) && !(SCALE_EN && inv_n);
    end else begin
`ifdef NTT_SCHED_SCALE_PASS_EN
      if (state_n == ST_SCALE) begin
        a_n     = bf_n;
        b_n     = bf_n;
        tf_n    = '0;
        scale_n = 1'b1;
        last_n  = (bf_n == SC_LAST);
      end else begin
        last_n  = 1'b0;
      end
`else
      last_n = 1'b0;
`endif
    end
  end

  // State, counters and all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      after_r   <= ST_IDLE;
      s_r       <= '0;
      bf_r      <= '0;
      drain_r   <= '0;
      inv       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tf_addr   <= '0;
      stage     <= '0;
      last      <= 1'b0;
`ifdef NTT_SCHED_SCALE_PASS_EN
      scale     <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      after_r   <= after_n;
      s_r       <= s_n;
      bf_r      <= bf_n;
      drain_r   <= drain_n;
      inv       <= inv_n;
      busy      <= (state_n != ST_IDLE);
      done      <= (state_n == ST_DONE);
      out_valid <= valid_n;
      addr_a    <= a_n;
      addr_b    <= b_n;
      tf_addr   <= tf_n;
      stage     <= s_n;
      last      <= last_n;
`ifdef NTT_SCHED_SCALE_PASS_EN
      scale     <= scale_n;
`endif
    end
  end

endmodule
